// File: rtl/rom_upload.sv
// Byte read-back streamer: serves HPS ioctl upload reads from a ROM image in SDRAM,
// undoing the optional 64-byte reorder. Define ROM_UPLOAD_CACHE_EN for a one-word read cache.
module rom_upload #(
    parameter logic [24:0] BASE_ADDR   = 25'h0,
    parameter logic [23:0] REGION_SIZE = 24'h100000,
    parameter logic        REORDER_64  = 1'b0
) (
    input  logic        sys_clk,
    input  logic        reset,
    input  logic        ioctl_upload,
    input  logic        ioctl_rd,
    input  logic [24:0] ioctl_addr,
    output logic [7:0]  ioctl_din,
    output logic        ioctl_wait,
    output logic [24:0] sdr_addr,
    output logic        sdr_req,
    input  logic        sdr_rdy,
    input  logic [15:0] sdr_q
);

    typedef enum logic [0:0] {IDLE, READ} state_t;

    state_t      state;
    state_t      state_next;
    logic [24:0] phys;
    logic [24:0] word_addr;
    logic        in_range;
    logic        rd_go;
    logic        cache_hit;
    logic [15:0] hit_word;
    logic        lane;
    logic        do_oor;
    logic        do_hit;
    logic        do_miss;
    logic        do_done;

    assign phys      = REORDER_64 ? {ioctl_addr[24:7], ioctl_addr[5:2], ioctl_addr[6], ioctl_addr[1:0]}
                                  : ioctl_addr;
    assign word_addr = BASE_ADDR + {phys[24:1], 1'b0};
    assign in_range  = ioctl_addr < {1'b0, REGION_SIZE};
    assign rd_go     = ioctl_rd & ioctl_upload;

`ifdef ROM_UPLOAD_CACHE_EN
    logic        upload_q;
    logic        upload_rise;
    logic        cache_valid;
    logic [24:0] cache_tag;
    logic [15:0] cache_data;

    assign upload_rise = ioctl_upload & ~upload_q;
    // A read arriving with the session's rising edge must not see the previous session's word.
    assign cache_hit   = cache_valid & ~upload_rise & (cache_tag == word_addr);
    assign hit_word    = cache_data;

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            upload_q    <= 1'b0;
            cache_valid <= 1'b0;
            cache_tag   <= '0;
            cache_data  <= '0;
        end else begin
            upload_q <= ioctl_upload;
            if (upload_rise) begin
                cache_valid <= 1'b0;
            end else if (do_done) begin
                cache_valid <= 1'b1;
                cache_tag   <= sdr_addr;
                cache_data  <= sdr_q;
            end
        end
    end
`else
    assign cache_hit = 1'b0;
    assign hit_word  = '0;
`endif

    // SDRAM handshake: sdr_req is a level held with a stable sdr_addr from issue until the
    // cycle after the single-cycle sdr_rdy pulse; sdr_rdy outside READ carries no meaning.
    always_comb begin
        state_next = state;
        do_oor     = 1'b0;
        do_hit     = 1'b0;
        do_miss    = 1'b0;
        do_done    = 1'b0;
        case (state)
            IDLE: begin
                if (rd_go) begin
                    if (!in_range) begin
                        do_oor = 1'b1;
                    end else if (cache_hit) begin
                        do_hit = 1'b1;
                    end else begin
                        do_miss    = 1'b1;
                        state_next = READ;
                    end
                end
            end
            READ: begin
                if (sdr_rdy) begin
                    do_done    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            ioctl_din  <= 8'h00;
            ioctl_wait <= 1'b0;
            sdr_req    <= 1'b0;
            sdr_addr   <= '0;
            lane       <= 1'b0;
        end else begin
            if (do_oor) begin
                ioctl_din <= 8'hFF;
            end
            if (do_hit) begin
                ioctl_din <= phys[0] ? hit_word[15:8] : hit_word[7:0];
            end
            if (do_miss) begin
                sdr_addr   <= word_addr;
                sdr_req    <= 1'b1;
                ioctl_wait <= 1'b1;
                lane       <= phys[0];
            end
            if (do_done) begin
                sdr_req    <= 1'b0;
                ioctl_wait <= 1'b0;
                ioctl_din  <= lane ? sdr_q[15:8] : sdr_q[7:0];
            end
        end
    end

endmodule

// File: tb/tb_rom_upload.sv
// Bench for rom_upload: two instances (linear and reordered) share the ioctl stimulus and
// each gets its own SDRAM responder; results are compared against a byte-level model.
module tb_rom_upload;

    localparam logic [24:0] BASE0   = 25'h2000;
    localparam logic [23:0] REGION0 = 24'h100;
    localparam logic [24:0] BASE1   = 25'h0;
    localparam logic [23:0] REGION1 = 24'h100000;

`ifdef ROM_UPLOAD_CACHE_EN
    localparam bit CACHE_ON = 1'b1;
`else
    localparam bit CACHE_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             ioctl_upload;
    logic             ioctl_rd;
    logic [24:0]      ioctl_addr;
    logic [1:0][7:0]  din;
    logic [1:0]       wt;
    logic [1:0]       req;
    logic [1:0]       rdy;
    logic [1:0][24:0] sdr_addr;
    logic [1:0][15:0] sdr_q;

    int n_checks = 0;
    int n_errors = 0;

    int          req_cnt[2];
    bit          pend[2];
    int          cnt[2];
    int          dly[2];
    bit          rsp_en;
    bit          cv[2];
    logic [24:0] ct[2];
    logic [24:0] exp_w[2];
    logic [7:0]  last_din[2];
    logic [7:0]  exp_q[$];

    always #5 clk = ~clk;

    rom_upload #(.BASE_ADDR(BASE0), .REGION_SIZE(REGION0), .REORDER_64(1'b0)) dut0 (
        .sys_clk(clk), .reset(reset), .ioctl_upload(ioctl_upload), .ioctl_rd(ioctl_rd),
        .ioctl_addr(ioctl_addr), .ioctl_din(din[0]), .ioctl_wait(wt[0]),
        .sdr_addr(sdr_addr[0]), .sdr_req(req[0]), .sdr_rdy(rdy[0]), .sdr_q(sdr_q[0])
    );

    rom_upload #(.BASE_ADDR(BASE1), .REGION_SIZE(REGION1), .REORDER_64(1'b1)) dut1 (
        .sys_clk(clk), .reset(reset), .ioctl_upload(ioctl_upload), .ioctl_rd(ioctl_rd),
        .ioctl_addr(ioctl_addr), .ioctl_din(din[1]), .ioctl_wait(wt[1]),
        .sdr_addr(sdr_addr[1]), .sdr_req(req[1]), .sdr_rdy(rdy[1]), .sdr_q(sdr_q[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mem_word(input logic [24:0] w);
        logic [7:0] i;
        if (w == 25'h2010) return 16'hBBAA;
        i = w[8:1];
        return {i ^ 8'hC3, i + 8'h5B};
    endfunction

    function automatic logic [24:0] phys_off(input logic [24:0] a, input bit reorder);
        if (!reorder) return a;
        return (a & ~25'h7F) | ((a & 25'h3C) << 1) | ((a >> 4) & 25'h4) | (a & 25'h3);
    endfunction

    // One cycle: step to the falling edge, then let each SDRAM responder act.
    task automatic tick();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            if (rdy[k]) begin
                rdy[k] = 1'b0;
            end else if (rsp_en) begin
                if (!pend[k] && req[k]) begin
                    pend[k] = 1'b1;
                    cnt[k]  = dly[k];
                    req_cnt[k]++;
                end
                if (pend[k]) begin
                    if (cnt[k] == 0) begin
                        check($sformatf("sdr_addr_hold%0d", k), sdr_addr[k], exp_w[k]);
                        sdr_q[k] = mem_word(sdr_addr[k]);
                        rdy[k]   = 1'b1;
                        pend[k]  = 1'b0;
                    end else begin
                        cnt[k]--;
                    end
                end
            end
        end
    endtask

    task automatic set_upload(input logic v);
        if (v && !ioctl_upload) begin
            cv[0] = 1'b0;
            cv[1] = 1'b0;
        end
        ioctl_upload = v;
        tick();
    endtask

    task automatic do_read(input logic [24:0] a, input int d0, input int d1, input bit extra);
        bit          miss[2];
        int          wc[2];
        int          rc[2];
        bit          done;
        logic [24:0] p;
        logic [24:0] w;
        logic [15:0] mw;
        logic [7:0]  e;
        for (int k = 0; k < 2; k++) begin
            p  = phys_off(a, k == 1);
            w  = (k == 1 ? BASE1 : BASE0) + (p & ~25'h1);
            mw = mem_word(w);
            if (a >= {1'b0, (k == 1 ? REGION1 : REGION0)}) begin
                e       = 8'hFF;
                miss[k] = 1'b0;
            end else begin
                e       = p[0] ? mw[15:8] : mw[7:0];
                miss[k] = !(CACHE_ON && cv[k] && ct[k] == w);
            end
            if (miss[k]) begin
                cv[k]    = 1'b1;
                ct[k]    = w;
                exp_w[k] = w;
            end
            dly[k]      = (k == 1) ? d1 : d0;
            rc[k]       = req_cnt[k];
            wc[k]       = 0;
            last_din[k] = e;
            exp_q.push_back(e);
        end
        ioctl_addr = a;
        ioctl_rd   = 1'b1;
        tick();
        ioctl_rd = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("req_rise%0d a=%0h", k, a), req[k], miss[k]);
            if (miss[k]) check($sformatf("req_addr%0d a=%0h", k, a), sdr_addr[k], exp_w[k]);
        end
        done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            for (int k = 0; k < 2; k++) if (wt[k]) wc[k]++;
            if (wt == 2'b00) begin
                done = 1'b1;
                break;
            end
            if (extra && i == 2) begin
                ioctl_addr = a ^ 25'h40;
                ioctl_rd   = 1'b1;
            end else begin
                ioctl_rd = 1'b0;
            end
            tick();
        end
        ioctl_rd = 1'b0;
        if (!done) check($sformatf("wait_timeout a=%0h", a), 1, 0);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("wait_cycles%0d a=%0h", k, a), wc[k], miss[k] ? dly[k] + 1 : 0);
            check($sformatf("din%0d a=%0h", k, a), din[k], exp_q.pop_front());
            check($sformatf("req_count%0d a=%0h", k, a), req_cnt[k] - rc[k], miss[k]);
        end
    endtask

    initial begin
        int          s0;
        logic [24:0] a;
        logic [24:0] prev;
        int          r;
        reset        = 1'b1;
        ioctl_upload = 1'b0;
        ioctl_rd     = 1'b0;
        ioctl_addr   = '0;
        rdy          = '0;
        sdr_q        = '0;
        rsp_en       = 1'b1;
        for (int k = 0; k < 2; k++) begin
            req_cnt[k] = 0; pend[k] = 0; cnt[k] = 0; dly[k] = 0;
            cv[k] = 0; ct[k] = '0; exp_w[k] = '0; last_din[k] = 8'h00;
        end
        repeat (3) tick();
        reset = 1'b0;
        tick();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst_din%0d", k), din[k], 8'h00);
            check($sformatf("rst_wait%0d", k), wt[k], 1'b0);
            check($sformatf("rst_req%0d", k), req[k], 1'b0);
            check($sformatf("rst_addr%0d", k), sdr_addr[k], 25'h0);
        end

        set_upload(1'b1);
        s0 = req_cnt[0];
        do_read(25'h10, 2, 1, 1'b0);
        do_read(25'h11, 2, 1, 1'b0);
        check("pair_reqs", req_cnt[0] - s0, CACHE_ON ? 1 : 2);

        do_read(25'h44, 1, 0, 1'b0);
        do_read(25'h04, 0, 2, 1'b0);
        do_read(25'h100, 1, 1, 1'b0);
        do_read(25'h0FF, 0, 0, 1'b0);
        do_read(25'h80, 7, 7, 1'b1);

        do_read(25'h30, 1, 1, 1'b0);
        set_upload(1'b0);
        set_upload(1'b1);
        do_read(25'h31, 1, 1, 1'b0);

        set_upload(1'b0);
        s0 = req_cnt[0] + req_cnt[1];
        ioctl_addr = 25'h20;
        ioctl_rd   = 1'b1;
        tick();
        ioctl_rd = 1'b0;
        tick();
        tick();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("ign_req%0d", k), req[k], 1'b0);
            check($sformatf("ign_din%0d", k), din[k], last_din[k]);
        end
        check("ign_req_count", req_cnt[0] + req_cnt[1] - s0, 0);
        set_upload(1'b1);

        prev = 25'h0;
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                set_upload(1'b0);
                set_upload(1'b1);
            end
            if (r < 5 && prev[0] == 1'b0) a = prev + 25'h1;
            else a = 25'($urandom_range(0, 511));
            do_read(a, $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
            prev = a;
        end

        rsp_en = 1'b0;
        set_upload(1'b0);
        set_upload(1'b1);
        ioctl_addr = 25'hE8;
        ioctl_rd   = 1'b1;
        tick();
        ioctl_rd = 1'b0;
        tick();
        for (int k = 0; k < 2; k++) check($sformatf("pre_rst_req%0d", k), req[k], 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("midrst_req%0d", k), req[k], 1'b0);
            check($sformatf("midrst_wait%0d", k), wt[k], 1'b0);
            pend[k] = 1'b0;
            cv[k]   = 1'b0;
        end
        sdr_q = {16'h1234, 16'h5678};
        rdy   = 2'b11;
        tick();
        rdy = 2'b00;
        tick();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("late_rdy_din%0d", k), din[k], 8'h00);
            check($sformatf("late_rdy_req%0d", k), req[k], 1'b0);
            check($sformatf("late_rdy_wait%0d", k), wt[k], 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
